// File: rtl/mp_add_pkg.sv
// Shared types and constants for the byte-serial multi-precision add/subtract sequencer.
package mp_add_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mp_add_seq_adder8.sv
// 8-bit ripple-carry adder used once per byte by the sequencer.
module ADDER8bit
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);

    // Full-adder chain; carry ripples from bit 0 upwards.
    always_comb begin
        logic [BYTE_W:0] v_c;
        v_c    = '0;
        o_sum  = '0;
        v_c[0] = i_cin;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ v_c[i];
            v_c[i+1]  = (i_a[i] & i_b[i]) | (v_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = v_c[BYTE_W];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add/subtract sequencer: one ADDER8bit per byte,
// carry fed back through a register, LSB-first valid/ready streams.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned LW        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LW-1:0]     len_m1,
    input  logic              sub,
    input  logic [BYTE_W-1:0] a_byte,
    input  logic [BYTE_W-1:0] b_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] sum_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              cout,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    // Longest legal length; requests beyond it are clamped when latched.
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BYTES - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic              w_in_ready;
    logic              w_start_acc;
    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_drain_hs;

    logic [LW-1:0]     r_len_m1;
    logic [LW-1:0]     r_count;
    logic              r_sub;
    logic              r_carry;
    logic [BYTE_W-1:0] r_sum;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_cout;
    logic              r_ovf;
    logic              r_done;

    logic [BYTE_W-1:0] w_b_eff;
    logic [BYTE_W-1:0] w_sum;
    logic              w_cout;

    // Subtraction is A + ~B + 1; the +1 comes from the carry preset at start.
    assign w_b_eff = b_byte ^ {BYTE_W{r_sub}};

    ADDER8bit u_adder (
        .i_a    (a_byte),
        .i_b    (w_b_eff),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start_acc = 1'b0;
        w_xfer      = 1'b0;
        w_last_xfer = 1'b0;
        w_drain_hs  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_in_ready  = !r_out_valid || out_ready;
                w_xfer      = in_valid && w_in_ready;
                w_last_xfer = w_xfer && (r_count == r_len_m1);
                if (w_last_xfer) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_drain_hs = r_out_valid && out_ready;
                if (w_drain_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operation context, carry chain and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_m1    <= '0;
            r_count     <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_len_m1 <= (len_m1 > LEN_MAX) ? LEN_MAX : len_m1;
                r_sub    <= sub;
                r_carry  <= sub;
                r_count  <= '0;
            end
            if (w_xfer) begin
                r_sum       <= w_sum;
                r_carry     <= w_cout;
                r_out_valid <= 1'b1;
                if (w_last_xfer) begin
                    r_out_last <= 1'b1;
                    r_cout     <= w_cout;
                    r_ovf      <= signed_ovf(a_byte[BYTE_W-1], w_b_eff[BYTE_W-1], w_sum[BYTE_W-1]);
                end else begin
                    r_count <= r_count + LW'(1);
                end
            end else if (w_drain_hs) begin
                // Final byte taken by the sink: close out the operation.
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_done      <= 1'b1;
                r_count     <= '0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign sum_byte  = r_sum;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq.
module tb_mp_add_seq;

    localparam int unsigned LW = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len_m1;
    logic          sub;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    sum_byte;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          cout;
    logic          ovf;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    mp_add_seq #(.MAX_BYTES(4), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_m1    (len_m1),
        .sub       (sub),
        .a_byte    (a_byte),
        .b_byte    (b_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_byte  (sum_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full operation with out_ready held high; expected bytes/flags come from the caller.
    task automatic run_op(input string name, input logic [LW-1:0] len, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input logic exp_cout, input logic exp_ovf);
        start  = 1'b1;
        len_m1 = len;
        sub    = s;
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, in_ready, done} !== 3'b110) begin
            errors++;
            $display("FAIL %s start: busy/in_ready/done=%b expected 110", name, {busy, in_ready, done});
        end
        for (int i = 0; i <= int'(len); i++) begin
            a_byte   = a[8*i +: 8];
            b_byte   = b[8*i +: 8];
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready byte %0d: got %b expected 1", name, i, in_ready);
            end
            cyc();
            checks++;
            if ({out_valid, out_last, sum_byte} !== {1'b1, (i == int'(len)), exp[8*i +: 8]}) begin
                errors++;
                $display("FAIL %s byte %0d: valid/last/sum=%b/%b/%h expected 1/%b/%h",
                         name, i, out_valid, out_last, sum_byte, (i == int'(len)), exp[8*i +: 8]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({cout, ovf} !== {exp_cout, exp_ovf}) begin
            errors++;
            $display("FAIL %s flags: cout/ovf=%b/%b expected %b/%b", name, cout, ovf, exp_cout, exp_ovf);
        end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain in_ready: got %b expected 0", name, in_ready);
        end
        cyc();
        checks++;
        if ({done, busy, out_valid, out_last} !== 4'b1000) begin
            errors++;
            $display("FAIL %s done: done/busy/valid/last=%b expected 1000",
                     name, {done, busy, out_valid, out_last});
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        len_m1    = '0;
        sub       = 1'b0;
        a_byte    = 8'h00;
        b_byte    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, sum_byte, out_last, cout, ovf, busy, done} !== 15'h0) begin
            errors++;
            $display("FAIL reset values: got %h expected 0000",
                     {in_ready, out_valid, sum_byte, out_last, cout, ovf, busy, done});
        end
        cyc();
        cyc();
        rst      = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle ignores in_valid: in_ready=%b expected 0", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_add();
        run_op("add2", 2'd1, 1'b0, 32'h0000_01FF, 32'h0000_0001, 32'h0000_0200, 1'b0, 1'b0);
        // Restart in the done cycle.
        run_op("add4", 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        cyc();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done pulse width: done=%b expected 0", done);
        end
    endtask

    task automatic test_sub();
        run_op("sub05_07", 2'd0, 1'b1, 32'h05, 32'h07, 32'hFE, 1'b0, 1'b0);
        run_op("sub80_01", 2'd0, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_back_pressure();
        start  = 1'b1;
        len_m1 = 2'd3;
        sub    = 1'b0;
        cyc();
        start    = 1'b0;
        a_byte   = 8'h01;
        b_byte   = 8'h10;
        in_valid = 1'b1;
        cyc();
        checks++;
        if ({out_valid, sum_byte} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL bp first: valid/sum=%b/%h expected 1/11", out_valid, sum_byte);
        end
        out_ready = 1'b0;
        a_byte    = 8'h02;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp in_ready comb: got %b expected 0", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({in_ready, out_valid, sum_byte} !== {1'b0, 1'b1, 8'h11}) begin
                errors++;
                $display("FAIL bp hold %0d: ready/valid/sum=%b/%b/%h expected 0/1/11",
                         k, in_ready, out_valid, sum_byte);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp release: in_ready=%b expected 1", in_ready);
        end
        for (int i = 2; i <= 4; i++) begin
            cyc();
            checks++;
            if ({out_last, sum_byte} !== {(i == 4), 8'h10 + 8'(i)}) begin
                errors++;
                $display("FAIL bp byte %0d: last/sum=%b/%h expected %b/%h",
                         i, out_last, sum_byte, (i == 4), 8'h10 + 8'(i));
            end
            a_byte = 8'(i + 1);
            if (i == 4) in_valid = 1'b0;
        end
        cyc();
        checks++;
        if ({done, cout, busy} !== 3'b100) begin
            errors++;
            $display("FAIL bp done: done/cout/busy=%b expected 100", {done, cout, busy});
        end
    endtask

    task automatic test_reset_mid_op();
        start  = 1'b1;
        len_m1 = 2'd3;
        sub    = 1'b0;
        cyc();
        start    = 1'b0;
        a_byte   = 8'hFF;
        b_byte   = 8'hFF;
        in_valid = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({out_valid, sum_byte} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL rst_mid pre: valid/sum=%b/%h expected 1/ff", out_valid, sum_byte);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, sum_byte, out_last, cout, ovf, busy, done} !== 15'h0) begin
            errors++;
            $display("FAIL rst_mid async: got %h expected 0000",
                     {in_ready, out_valid, sum_byte, out_last, cout, ovf, busy, done});
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid no done: done/busy=%b expected 00", {done, busy});
        end
        run_op("post_rst", 2'd0, 1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_run();
        // 0x0300 - 0x0001 = 0x02FF, no borrow.
        start  = 1'b1;
        len_m1 = 2'd1;
        sub    = 1'b1;
        cyc();
        a_byte   = 8'h00;
        b_byte   = 8'h01;
        in_valid = 1'b1;
        len_m1   = 2'd0;
        sub      = 1'b0;
        cyc();
        start = 1'b0;
        checks++;
        if ({out_last, sum_byte, busy} !== {1'b0, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL start_in_run b0: last/sum/busy=%b/%h/%b expected 0/ff/1", out_last, sum_byte, busy);
        end
        a_byte = 8'h03;
        b_byte = 8'h00;
        cyc();
        in_valid = 1'b0;
        checks++;
        if ({out_last, sum_byte, cout, ovf} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_in_run b1: last/sum/cout/ovf=%b/%h/%b/%b expected 1/02/1/0",
                     out_last, sum_byte, cout, ovf);
        end
        cyc();
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL start_in_run done: done/busy=%b expected 10", {done, busy});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_pressure();
        test_reset_mid_op();
        test_start_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
